// File: rtl/counter_sequencer.sv
// Count-register sequencer: start/stop/pause control, up or down counting,
// one-shot or auto-reload, with a clock-enable prescaler.
module counter_sequencer #(
  parameter int WIDTH   = 4,
  parameter int PRESC_W = 8
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               START,
  input  logic               STOP,
  input  logic               PAUSE,
  input  logic [WIDTH-1:0]   LOAD_VAL,
  input  logic [PRESC_W-1:0] PRESC,
  input  logic               MODE,
  input  logic               DIR,
  output logic [WIDTH-1:0]   Q,
  output logic               BUSY,
  output logic               TC,
  output logic               DONE
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DONE} state_t;

  state_t             state;
  logic [PRESC_W-1:0] presc_cnt;
  logic [PRESC_W-1:0] presc_cap;
  logic [WIDTH-1:0]   term;
  logic               mode;
  logic               dir;
  logic               tick;
  logic               at_term;

  // Terminal detection precedes the step, so the count never wraps naturally.
  assign tick    = (presc_cnt == presc_cap);
  assign at_term = dir ? (Q == '0) : (Q == term);

  assign BUSY = (state == S_RUN) || (state == S_HOLD);
  assign DONE = (state == S_DONE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      Q         <= '0;
      TC        <= 1'b0;
      presc_cnt <= '0;
      presc_cap <= '0;
      term      <= '0;
      mode      <= 1'b0;
      dir       <= 1'b0;
    end else begin
      TC <= 1'b0;
      if (STOP) begin
        state     <= S_IDLE;
        Q         <= '0;
        presc_cnt <= '0;
      end else if (START) begin
        state     <= S_RUN;
        term      <= LOAD_VAL;
        presc_cap <= PRESC;
        mode      <= MODE;
        dir       <= DIR;
        Q         <= DIR ? LOAD_VAL : '0;
        presc_cnt <= '0;
      end else begin
        case (state)
          S_RUN: begin
            // A pause request suppresses any tick due in the same cycle.
            if (PAUSE) begin
              state <= S_HOLD;
            end else if (tick) begin
              presc_cnt <= '0;
              if (at_term) begin
                TC <= 1'b1;
                if (mode) Q <= dir ? term : '0;
                else      state <= S_DONE;
              end else begin
                Q <= dir ? (Q - 1'b1) : (Q + 1'b1);
              end
            end else begin
              presc_cnt <= presc_cnt + 1'b1;
            end
          end
          S_HOLD: begin
            if (!PAUSE) state <= S_RUN;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: behavioural model with per-cycle
// comparison plus hand-computed expectations along each scenario.
module tb_counter_sequencer;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       START = 1'b0;
  logic       STOP = 1'b0;
  logic       PAUSE = 1'b0;
  logic [3:0] LOAD_VAL = '0;
  logic [7:0] PRESC = '0;
  logic       MODE = 1'b0;
  logic       DIR = 1'b0;
  logic [3:0] Q;
  logic       BUSY;
  logic       TC;
  logic       DONE;

  int n_checks = 0;
  int n_err = 0;

  counter_sequencer #(.WIDTH(4), .PRESC_W(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP), .PAUSE(PAUSE),
    .LOAD_VAL(LOAD_VAL), .PRESC(PRESC), .MODE(MODE), .DIR(DIR),
    .Q(Q), .BUSY(BUSY), .TC(TC), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: activity flags plus a countdown to the next tick.
  int m_q, m_term, m_cap, m_left;
  bit m_mode, m_dir, m_active, m_paused, m_finished, m_tc;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_q <= 0; m_term <= 0; m_cap <= 0; m_left <= 0;
      m_mode <= 0; m_dir <= 0; m_active <= 0; m_paused <= 0;
      m_finished <= 0; m_tc <= 0;
    end else begin
      m_tc <= 0;
      if (STOP) begin
        m_active <= 0; m_paused <= 0; m_finished <= 0; m_q <= 0;
      end else if (START) begin
        m_term <= int'(LOAD_VAL); m_cap <= int'(PRESC); m_left <= int'(PRESC);
        m_mode <= MODE; m_dir <= DIR;
        m_q <= DIR ? int'(LOAD_VAL) : 0;
        m_active <= 1; m_paused <= 0; m_finished <= 0;
      end else if (m_active && m_paused) begin
        if (!PAUSE) m_paused <= 0;
      end else if (m_active) begin
        if (PAUSE) m_paused <= 1;
        else if (m_left > 0) m_left <= m_left - 1;
        else begin
          m_left <= m_cap;
          if ((m_dir && m_q == 0) || (!m_dir && m_q == m_term)) begin
            m_tc <= 1;
            if (m_mode) m_q <= m_dir ? m_term : 0;
            else begin
              m_active <= 0; m_finished <= 1;
            end
          end else begin
            m_q <= m_dir ? m_q - 1 : m_q + 1;
          end
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (RST_N) begin
      chk("model_q", 32'(Q), m_q);
      chk("model_busy", 32'(BUSY), 32'(m_active));
      chk("model_tc", 32'(TC), 32'(m_tc));
      chk("model_done", 32'(DONE), 32'(m_finished));
    end
  end

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic start_cfg(input int lv, input int pr, input bit md, input bit dr);
    LOAD_VAL = 4'(lv); PRESC = 8'(pr); MODE = md; DIR = dr; START = 1'b1;
    step();
    START = 1'b0;
    LOAD_VAL = 4'($urandom_range(0, 15)); PRESC = 8'($urandom_range(0, 255));
    MODE = 1'($urandom_range(0, 1)); DIR = 1'($urandom_range(0, 1));
  endtask

  task automatic stop_now();
    STOP = 1'b1;
    step();
    STOP = 1'b0;
  endtask

  int exp_q[13] = '{2, 2, 1, 1, 0, 0, 2, 2, 1, 1, 0, 0, 2};
  bit found;

  initial begin
    #2 RST_N = 1'b0;
    #1;
    chk("reset_q", 32'(Q), 0);
    chk("reset_busy", 32'(BUSY), 0);
    chk("reset_tc", 32'(TC), 0);
    chk("reset_done", 32'(DONE), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    step();

    // Up, one-shot to 3
    start_cfg(3, 0, 0, 0);
    chk("up_q0", 32'(Q), 0); chk("up_busy", 32'(BUSY), 1);
    step(); chk("up_q1", 32'(Q), 1);
    step(); chk("up_q2", 32'(Q), 2);
    step(); chk("up_q3", 32'(Q), 3); chk("up_tc_early", 32'(TC), 0);
    step(); chk("up_q3_hold", 32'(Q), 3); chk("up_tc", 32'(TC), 1);
    chk("up_done", 32'(DONE), 1); chk("up_busy_off", 32'(BUSY), 0);
    step(); chk("up_tc_clear", 32'(TC), 0); chk("up_done_hold", 32'(DONE), 1);
    chk("up_q_final", 32'(Q), 3);

    // Down, auto-reload from 2, each value held two cycles
    start_cfg(2, 1, 1, 1);
    for (int i = 0; i < 13; i++) begin
      chk("down_q", 32'(Q), exp_q[i]);
      chk("down_tc", 32'(TC), (i == 6 || i == 12) ? 1 : 0);
      chk("down_done", 32'(DONE), 0);
      step();
    end
    stop_now();
    chk("stop_q", 32'(Q), 0); chk("stop_busy", 32'(BUSY), 0);

    // Pause at Q=4 with prescale 4
    start_cfg(15, 3, 0, 0);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (Q == 4'd4) found = 1;
      else step();
    end
    chk("pause_reach4", 32'(found), 1);
    PAUSE = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("pause_q", 32'(Q), 4); chk("pause_busy", 32'(BUSY), 1);
    end
    PAUSE = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(); chk("resume_q4", 32'(Q), 4);
    end
    step(); chk("resume_q5", 32'(Q), 5);
    stop_now();

    // STOP beats START
    start_cfg(9, 0, 0, 0);
    step(); step(); chk("prio_q2", 32'(Q), 2);
    STOP = 1'b1; START = 1'b1;
    step();
    STOP = 1'b0; START = 1'b0;
    chk("prio_q", 32'(Q), 0); chk("prio_busy", 32'(BUSY), 0);

    // Re-arm from DONE
    start_cfg(1, 0, 0, 0);
    step(); chk("arm_q1", 32'(Q), 1);
    step(); chk("arm_done1", 32'(DONE), 1); chk("arm_tc1", 32'(TC), 1);
    start_cfg(1, 0, 0, 0);
    chk("rearm_q0", 32'(Q), 0); chk("rearm_done0", 32'(DONE), 0);
    chk("rearm_busy", 32'(BUSY), 1);
    step(); chk("rearm_q1", 32'(Q), 1);
    step(); chk("rearm_done", 32'(DONE), 1); chk("rearm_tc", 32'(TC), 1);

    // term=0, up one-shot
    start_cfg(0, 0, 0, 0);
    chk("t0_q", 32'(Q), 0); chk("t0_busy", 32'(BUSY), 1);
    step(); chk("t0_tc", 32'(TC), 1); chk("t0_done", 32'(DONE), 1);
    chk("t0_qhold", 32'(Q), 0);

    // term=15, up auto-reload: full range then reload without wrap
    start_cfg(15, 0, 1, 0);
    for (int i = 0; i < 16; i++) begin
      chk("t15_q", 32'(Q), i); chk("t15_tc", 32'(TC), 0);
      step();
    end
    chk("t15_reload_q", 32'(Q), 0); chk("t15_reload_tc", 32'(TC), 1);
    chk("t15_busy", 32'(BUSY), 1);
    step(); chk("t15_q1", 32'(Q), 1); chk("t15_tc_clear", 32'(TC), 0);
    stop_now();

    // Asynchronous reset mid-count
    start_cfg(15, 0, 0, 0);
    for (int i = 0; i < 5; i++) step();
    chk("mid_q5", 32'(Q), 5);
    #2 RST_N = 1'b0;
    #1;
    chk("areset_q", 32'(Q), 0); chk("areset_busy", 32'(BUSY), 0);
    chk("areset_done", 32'(DONE), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    step(); chk("post_reset_q", 32'(Q), 0); chk("post_reset_busy", 32'(BUSY), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
